// File: rtl/ahb_decoder_if.sv
// AHB decoder bus bundle: master-side address/response signals, the
// one-hot slave selects, and the data-phase select to the read mux.
interface ahb_decoder_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hreadyout_mux;
    logic        hresp_mux;
    logic        hsel_1;
    logic        hsel_2;
    logic        hsel_3;
    logic        hsel_4;
    logic [1:0]  sel;
    logic        hready;
    logic        hresp;

    // Bus master / read-mux side: drives address and slave responses.
    modport master (
        output haddr, htrans, hreadyout_mux, hresp_mux,
        input  hsel_1, hsel_2, hsel_3, hsel_4, sel, hready, hresp
    );

    // Decoder side.
    modport slave (
        input  haddr, htrans, hreadyout_mux, hresp_mux,
        output hsel_1, hsel_2, hsel_3, hsel_4, sel, hready, hresp
    );
endinterface

// File: rtl/ahb_decoder.sv
// AHB address decoder with data-phase select register and a built-in
// default slave that answers unmapped transfers with a two-cycle ERROR.
module ahb_decoder #(
    parameter int                        DEC_MSB  = 31,
    parameter int                        DEC_LSB  = 28,
    parameter logic [DEC_MSB-DEC_LSB:0]  REGION_1 = 4'h0,
    parameter logic [DEC_MSB-DEC_LSB:0]  REGION_2 = 4'h1,
    parameter logic [DEC_MSB-DEC_LSB:0]  REGION_3 = 4'h2,
    parameter logic [DEC_MSB-DEC_LSB:0]  REGION_4 = 4'h3
) (
    input  logic              hclk,
    input  logic              hreset,
    ahb_decoder_if.slave      bus,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLAVE = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [1:0]               r_sel;
    logic [7:0]               r_err_cnt;

    logic [DEC_MSB-DEC_LSB:0] w_field;
    logic                     w_hit1, w_hit2, w_hit3, w_hit4;
    logic                     w_mapped;
    logic [1:0]               w_idx;
    logic                     w_active;
    logic                     w_hready;
    logic                     w_hresp;
    logic                     w_load_sel;

    assign w_field  = bus.haddr[DEC_MSB:DEC_LSB];
    assign w_hit1   = (w_field == REGION_1);
    assign w_hit2   = (w_field == REGION_2);
    assign w_hit3   = (w_field == REGION_3);
    assign w_hit4   = (w_field == REGION_4);
    assign w_mapped = w_hit1 | w_hit2 | w_hit3 | w_hit4;
    assign w_active = bus.htrans[1];

    // Encode the matching region into the data-phase mux index.
    always_comb begin
        w_idx = 2'b00;
        if (w_hit1)      w_idx = 2'b00;
        else if (w_hit2) w_idx = 2'b01;
        else if (w_hit3) w_idx = 2'b10;
        else if (w_hit4) w_idx = 2'b11;
    end

    // Response outputs by data-phase state, plus next-state selection.
    always_comb begin
        w_hready     = 1'b1;
        w_hresp      = 1'b0;
        w_state_next = r_state;
        w_load_sel   = 1'b0;
        case (r_state)
            ST_SLAVE: begin
                w_hready = bus.hreadyout_mux;
                w_hresp  = bus.hresp_mux;
            end
            ST_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = 1'b1;
            end
            ST_ERR2: begin
                w_hready = 1'b1;
                w_hresp  = 1'b1;
            end
            default: begin
                w_hready = 1'b1;
                w_hresp  = 1'b0;
            end
        endcase

        if (r_state == ST_ERR1) begin
            w_state_next = ST_ERR2;
        end else if (w_hready) begin
            if (w_active && w_mapped) begin
                w_state_next = ST_SLAVE;
                w_load_sel   = 1'b1;
            end else if (w_active) begin
                w_state_next = ST_ERR1;
            end else begin
                w_state_next = ST_IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Data-phase select: loaded only on acceptance of a mapped transfer.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)          r_sel <= 2'b00;
        else if (w_load_sel) r_sel <= w_idx;
    end

    // Saturating count of default-slave ERROR responses (ERR1 entries).
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)
            r_err_cnt <= '0;
        else if (w_state_next == ST_ERR1 && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign bus.hsel_1 = w_hit1;
    assign bus.hsel_2 = w_hit2;
    assign bus.hsel_3 = w_hit3;
    assign bus.hsel_4 = w_hit4;
    assign bus.sel    = r_sel;
    assign bus.hready = w_hready;
    assign bus.hresp  = w_hresp;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_ahb_decoder.sv
// Scoreboard bench for ahb_decoder: stimulus pushes per-cycle expected
// outputs, a monitor pops and compares them mid-cycle.
module tb_ahb_decoder;

    logic       hclk;
    logic       hreset;
    logic [7:0] err_cnt;

    ahb_decoder_if bus ();

    ahb_decoder dut (
        .hclk    (hclk),
        .hreset  (hreset),
        .bus     (bus.slave),
        .err_cnt (err_cnt)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        string      name;
        logic [3:0] hsel;
        logic [1:0] sel;
        logic       hready;
        logic       hresp;
        logic [7:0] err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event chk_ev;

    localparam logic [31:0] A_UNMAP = 32'h8000_0000;

    // Monitor: compare every pending expectation against the DUT.
    initial begin
        exp_t       e;
        logic [3:0] act_hsel;
        forever begin
            @(negedge hclk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                act_hsel = {bus.hsel_4, bus.hsel_3, bus.hsel_2, bus.hsel_1};
                n_checks++;
                if (act_hsel !== e.hsel || bus.sel !== e.sel ||
                    bus.hready !== e.hready || bus.hresp !== e.hresp ||
                    err_cnt !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got hsel=%b sel=%b hready=%b hresp=%b err=%0d, want hsel=%b sel=%b hready=%b hresp=%b err=%0d",
                             e.name, act_hsel, bus.sel, bus.hready, bus.hresp, err_cnt,
                             e.hsel, e.sel, e.hready, e.hresp, e.err);
                end
            end
        end
    end

    task automatic push(input string name, input logic [3:0] hsel, input logic [1:0] sel,
                        input logic rdy, input logic resp, input logic [7:0] err);
        exp_t e;
        e.name = name; e.hsel = hsel; e.sel = sel;
        e.hready = rdy; e.hresp = resp; e.err = err;
        q.push_back(e);
    endtask

    // One bus cycle: drive inputs just after the edge and queue the
    // outputs expected for the remainder of that cycle.
    task automatic step(input string name, input logic rst, input logic [31:0] addr,
                        input logic [1:0] trans, input logic rdy_mux, input logic resp_mux,
                        input logic [3:0] e_hsel, input logic [1:0] e_sel,
                        input logic e_rdy, input logic e_resp, input logic [7:0] e_err);
        @(posedge hclk);
        #1;
        hreset            = rst;
        bus.haddr         = addr;
        bus.htrans        = trans;
        bus.hreadyout_mux = rdy_mux;
        bus.hresp_mux     = resp_mux;
        push(name, e_hsel, e_sel, e_rdy, e_resp, e_err);
    endtask

    initial begin
        int unsigned exp_err;
        hreset            = 1'b1;
        bus.haddr         = 32'h0;
        bus.htrans        = 2'b00;
        bus.hreadyout_mux = 1'b1;
        bus.hresp_mux     = 1'b0;
        #2;
        push("reset_state", 4'b0001, 2'b00, 1'b1, 1'b0, 8'd0);

        step("rst_hold",   1'b1, 32'h0, 2'b00, 1'b1, 1'b0, 4'b0001, 2'b00, 1, 0, 8'd0);
        step("rst_rel",    1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 4'b0001, 2'b00, 1, 0, 8'd0);

        // Mapped NONSEQ to slave 2, zero wait.
        step("s2_addr",    1'b0, 32'h1000_0040, 2'b10, 1, 0, 4'b0010, 2'b00, 1, 0, 8'd0);
        step("s2_data",    1'b0, 32'h0,         2'b00, 1, 0, 4'b0001, 2'b01, 1, 0, 8'd0);

        // NONSEQ slave 3 then SEQ slave 2 with two wait states.
        step("s3_addr",    1'b0, 32'h2000_0000, 2'b10, 1, 0, 4'b0100, 2'b01, 1, 0, 8'd0);
        step("s3_wait1",   1'b0, 32'h1000_0000, 2'b11, 0, 0, 4'b0010, 2'b10, 0, 0, 8'd0);
        step("s3_wait2",   1'b0, 32'h1000_0000, 2'b11, 0, 0, 4'b0010, 2'b10, 0, 0, 8'd0);
        step("s3_done",    1'b0, 32'h1000_0000, 2'b11, 1, 0, 4'b0010, 2'b10, 1, 0, 8'd0);
        step("s2_seq_rsp", 1'b0, 32'h0,         2'b00, 1, 1, 4'b0001, 2'b01, 1, 1, 8'd0);

        // Unmapped NONSEQ: two-cycle ERROR.
        step("um_addr",    1'b0, A_UNMAP, 2'b10, 1, 0, 4'b0000, 2'b01, 1, 0, 8'd0);
        step("um_err1",    1'b0, 32'h0,   2'b00, 1, 0, 4'b0001, 2'b01, 0, 1, 8'd1);
        step("um_err2",    1'b0, 32'h0,   2'b00, 1, 0, 4'b0001, 2'b01, 1, 1, 8'd1);
        step("um_idle",    1'b0, 32'h0,   2'b00, 1, 0, 4'b0001, 2'b01, 1, 0, 8'd1);

        // IDLE and BUSY to unmapped space are not transfers.
        step("idle_um",    1'b0, A_UNMAP, 2'b00, 1, 0, 4'b0000, 2'b01, 1, 0, 8'd1);
        step("busy_um",    1'b0, A_UNMAP, 2'b01, 1, 0, 4'b0000, 2'b01, 1, 0, 8'd1);
        step("after_busy", 1'b0, 32'h0,   2'b00, 1, 0, 4'b0001, 2'b01, 1, 0, 8'd1);

        // ERROR, master changes address in ERR1, mapped follows ERR2,
        // then unmapped directly follows SLAVE.
        step("b2b_um",     1'b0, A_UNMAP,       2'b10, 1, 0, 4'b0000, 2'b01, 1, 0, 8'd1);
        step("b2b_err1",   1'b0, 32'h3000_0000, 2'b10, 1, 0, 4'b1000, 2'b01, 0, 1, 8'd2);
        step("b2b_err2",   1'b0, 32'h3000_0000, 2'b10, 1, 0, 4'b1000, 2'b01, 1, 1, 8'd2);
        step("b2b_s4",     1'b0, A_UNMAP,       2'b10, 1, 0, 4'b0000, 2'b11, 1, 0, 8'd2);
        step("b2b_err1b",  1'b0, 32'h0,         2'b00, 1, 0, 4'b0001, 2'b11, 0, 1, 8'd3);

        // Asynchronous reset while in ERR1, checked before any edge.
        #1;
        -> chk_ev;
        #1;
        hreset = 1'b1;
        #1;
        push("rst_in_err1", 4'b0001, 2'b00, 1'b1, 1'b0, 8'd0);
        -> chk_ev;
        step("rst_hold2",  1'b1, 32'h0, 2'b00, 1, 0, 4'b0001, 2'b00, 1, 0, 8'd0);
        step("rst_rel2",   1'b0, 32'h0, 2'b00, 1, 0, 4'b0001, 2'b00, 1, 0, 8'd0);

        // 260 back-to-back unmapped transfers: counter saturates at 255.
        step("sat_first",  1'b0, A_UNMAP, 2'b10, 1, 0, 4'b0000, 2'b00, 1, 0, 8'd0);
        for (int i = 0; i < 260; i++) begin
            exp_err = (i + 1 > 255) ? 255 : i + 1;
            step("sat_err1", 1'b0, A_UNMAP, 2'b10, 1, 0, 4'b0000, 2'b00, 0, 1, exp_err[7:0]);
            step("sat_err2", 1'b0, A_UNMAP, (i == 259) ? 2'b00 : 2'b10, 1, 0,
                 4'b0000, 2'b00, 1, 1, exp_err[7:0]);
        end
        step("sat_idle",   1'b0, 32'h0, 2'b00, 1, 0, 4'b0001, 2'b00, 1, 0, 8'hFF);

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge hclk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ahb_decoder.md
# ahb_decoder

AHB address decoder and response controller for the four-slave AHB subsystem. It decodes the master's address-phase `haddr` into one-hot slave selects `hsel_1`..`hsel_4`. It registers the decoded slave index as the data-phase select that steers the slave-to-master read-data/response multiplexor. It contains a built-in default slave that returns the two-cycle AHB ERROR response for transfers to unmapped addresses, and it drives the final `hready`/`hresp` seen by the master and all slaves.

## Interface
- `DEC_MSB`, default 31: MSB of the region field in `haddr`.
- `DEC_LSB`, default 28: LSB of the region field in `haddr`.
- `REGION_1`, default 4'h0: region value mapped to slave 1; `REGION_2`/`REGION_3`/`REGION_4` default 4'h1/4'h2/4'h3.

Ports:
- `hclk`  in  1  system clock; all state changes on rising edge.
- `hreset`  in  1  asynchronous, active-high reset.
- `haddr`  in  32  address-phase address.
- `htrans`  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hreadyout_mux`  in  1  selected slave's hreadyout, from the read multiplexor.
- `hresp_mux`  in  1  selected slave's hresp, from the read multiplexor.
- `hsel_1`..`hsel_4`  out  1 each  combinational one-hot slave selects.
- `sel`  out  2  registered data-phase slave index (00 = slave 1 … 11 = slave 4) to the multiplexor.
- `hready`  out  1  bus-wide transfer-done.
- `hresp`  out  1  bus response: 0 OKAY, 1 ERROR.
- `err_cnt`  out  8  saturating count of ERROR responses issued by the default slave.

## Operation
- Decode is combinational. It uses `haddr[DEC_MSB:DEC_LSB]` only and ignores `htrans`.
  - `hsel_n` = 1 when the field equals `REGION_n`.
  - When no region matches, the address is unmapped and all `hsel` are 0.
  - Slaves qualify their select with `htrans` and `hready` themselves.
- An address phase is accepted on a rising edge where `hready`=1.
  - An active transfer means `htrans[1]`=1 (NONSEQ or SEQ).
  - IDLE and BUSY are never active transfers.
- Data-phase state machine:
  - IDLE: no active data phase. `hready`=1, `hresp`=0.
  - SLAVE: a mapped slave owns the data phase. `hready`=`hreadyout_mux`, `hresp`=`hresp_mux`.
  - ERR1: `hready`=0, `hresp`=1.
  - ERR2: `hready`=1, `hresp`=1.
- Transitions, taken from IDLE, SLAVE or ERR2 only when `hready`=1:
  - active transfer to a mapped address → SLAVE, and load `sel` with the decoded index;
  - active transfer to an unmapped address → ERR1;
  - otherwise → IDLE.
- ERR1 → ERR2 unconditionally on the next edge. No address phase is accepted in ERR1, because `hready`=0.
- While `hready`=0, `sel` and the state hold. `sel` changes only on acceptance of a mapped active transfer and otherwise keeps its last value.
- `err_cnt` increments by 1 on every ERR1 entry and saturates at 8'hFF.
- The master may change `htrans`/`haddr` during wait states, for example abandoning a transfer in ERR1. Only the values present on an `hready`=1 edge are used.

## Timing
- Reset, asynchronous, effective immediately:
  - state=IDLE, `sel`=00, `err_cnt`=0;
  - therefore `hready`=1 and `hresp`=0 while `hreset`=1 and after release.
  - `hsel_*` remain combinational from `haddr` during reset.
- `hsel_*` have zero latency: valid in the same cycle as `haddr`.
- `sel` and the state update one edge after the address phase. `hready`/`hresp` are valid from that cycle onward.
- Unmapped active transfer:
  - exactly one cycle of `hready`=0/`hresp`=1, then one cycle of `hready`=1/`hresp`=1;
  - the next address phase is accepted on the ERR2 edge.
- Back-to-back transfers with zero-wait slaves give one transfer per cycle. A mapped transfer may directly follow ERR2, and an unmapped one may follow SLAVE.
- Reset asserted mid-wait-state or in ERR1/ERR2 aborts the transfer. IDLE outputs appear immediately.

## Test plan
- Reset: assert `hreset` with the state in ERR1 → `hready`=1, `hresp`=0, `sel`=00, `err_cnt`=0 with no clock edge required.
- NONSEQ to 32'h1000_0040, `hreadyout_mux`=1 → `hsel_2`=1 in the same cycle; next cycle `sel`=01, `hready`=1, `hresp`=0.
- NONSEQ to 32'h2000_0000, then SEQ to 32'h1000_0000, with `hreadyout_mux`=0 for 2 cycles → `sel` holds 10 and `hready`=0 for 2 cycles. `sel` becomes 01 only after the edge where `hready`=1.
- NONSEQ to 32'h8000_0000 → all `hsel`=0; next cycle `hready`=0, `hresp`=1; following cycle `hready`=1, `hresp`=1; then IDLE with `hresp`=0; `err_cnt`=1.
- IDLE and BUSY to 32'h8000_0000 → `hready`=1, `hresp`=0, no ERROR, `err_cnt` unchanged.
- 260 consecutive unmapped NONSEQ transfers → `err_cnt` reaches 8'hFF and stays there, and every transfer still gets the two-cycle ERROR.
